// File: rtl/if_fetch_stage.sv
// MIPS32 instruction fetch: owns the PC, requests words over req/ready and feeds IF/ID.
// Optional perf counters (fetchCount, stallCount) are built when IF_PERF_COUNTERS_EN is defined.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC       = 32'h00000000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] pcOut,
  output logic [31:0] instOut,
  output logic        validOut,
  output logic        fetchErr,
  output logic [31:0] fetchCount,
  output logic [31:0] stallCount
);

  typedef enum logic [1:0] {FETCH, DROP, HOLD, ERR} state_t;

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      stateReg;
  logic [31:0] pcReg;
  logic [31:0] pendPcReg;
  logic [31:0] holdBufReg;
  logic [31:0] wdCountReg;
  logic [31:0] pcOutReg;
  logic [31:0] instOutReg;
  logic        validOutReg;
  logic        fetchErrReg;

  logic [31:0] redirTarget;
  logic [31:0] pcPlus4;
  logic        reqActive;
  logic        waiting;
  logic        wdExpire;
  logic        loadValid;

  assign redirTarget = redirectPc & ~32'h3;
  assign pcPlus4     = pcReg + 32'd4;
  assign reqActive   = (stateReg == FETCH) || (stateReg == DROP);
  assign imemReq     = reqActive && !rst;
  assign imemAddr    = pcReg;
  assign waiting     = reqActive && !imemReady;
  assign wdExpire    = (TIMEOUT_LIMIT != 32'd0) && waiting && ((wdCountReg + 32'd1) == TIMEOUT_LIMIT);

  // A new instruction reaches IF/ID either straight from memory or from the stall buffer.
  assign loadValid = !rst && !redirect && !stall &&
                     (((stateReg == FETCH) && imemReady) || (stateReg == HOLD));

  assign pcOut    = pcOutReg;
  assign instOut  = instOutReg;
  assign validOut = validOutReg;
  assign fetchErr = fetchErrReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= FETCH;
      pcReg       <= RESET_PC & ~32'h3;
      pendPcReg   <= 32'd0;
      holdBufReg  <= 32'd0;
      wdCountReg  <= 32'd0;
      pcOutReg    <= 32'd0;
      instOutReg  <= 32'd0;
      validOutReg <= 1'b0;
      fetchErrReg <= 1'b0;
    end else if (wdExpire) begin
      stateReg    <= ERR;
      fetchErrReg <= 1'b1;
      validOutReg <= 1'b0;
      instOutReg  <= 32'd0;
    end else begin
      if (waiting)
        wdCountReg <= wdCountReg + 32'd1;
      else if (imemReady)
        wdCountReg <= 32'd0;

      case (stateReg)
        FETCH: begin
          if (imemReady) begin
            if (redirect) begin
              pcReg       <= redirTarget;
              validOutReg <= 1'b0;
              instOutReg  <= 32'd0;
            end else if (stall) begin
              holdBufReg <= imemData;
              stateReg   <= HOLD;
            end else begin
              instOutReg  <= imemData;
              pcOutReg    <= pcPlus4;
              validOutReg <= 1'b1;
              pcReg       <= pcPlus4;
            end
          end else if (redirect) begin
            // The outstanding request cannot be withdrawn; wait it out in DROP.
            pendPcReg   <= redirTarget;
            stateReg    <= DROP;
            validOutReg <= 1'b0;
            instOutReg  <= 32'd0;
          end else if (!stall) begin
            validOutReg <= 1'b0;
            instOutReg  <= 32'd0;
          end
        end
        DROP: begin
          if (imemReady) begin
            pcReg    <= redirect ? redirTarget : pendPcReg;
            stateReg <= FETCH;
          end else if (redirect) begin
            pendPcReg <= redirTarget;
          end
          if (redirect || !stall) begin
            validOutReg <= 1'b0;
            instOutReg  <= 32'd0;
          end
        end
        HOLD: begin
          if (redirect) begin
            pcReg       <= redirTarget;
            validOutReg <= 1'b0;
            instOutReg  <= 32'd0;
            stateReg    <= FETCH;
          end else if (!stall) begin
            instOutReg  <= holdBufReg;
            pcOutReg    <= pcPlus4;
            validOutReg <= 1'b1;
            pcReg       <= pcPlus4;
            stateReg    <= FETCH;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetchCountReg;
  logic [31:0] stallCountReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchCountReg <= 32'd0;
      stallCountReg <= 32'd0;
    end else begin
      if (loadValid)
        fetchCountReg <= fetchCountReg + 32'd1;
      if (stall && (stateReg != ERR))
        stallCountReg <= stallCountReg + 32'd1;
    end
  end

  assign fetchCount = fetchCountReg;
  assign stallCount = stallCountReg;
`else
  logic unusedLoadValid;
  assign unusedLoadValid = loadValid;
  assign fetchCount      = 32'd0;
  assign stallCount      = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: zero-wait and slow memory, stall, redirect, watchdog.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic [31:0] pcOut;
  logic [31:0] instOut;
  logic        validOut;
  logic        fetchErr;
  logic [31:0] fetchCount;
  logic [31:0] stallCount;

  int vecCount = 0;
  int errCount = 0;

  // Memory model: memLat=1 answers in the request cycle, memLat=N in the Nth cycle.
  int   memLat;
  int   waitCnt;
  logic memOn;

  if_fetch_stage #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPc(redirectPc),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
    .pcOut(pcOut), .instOut(instOut), .validOut(validOut), .fetchErr(fetchErr),
    .fetchCount(fetchCount), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0:   memWord = 32'h20080001;
      32'h4:   memWord = 32'h20090002;
      32'h8:   memWord = 32'h01095020;
      default: memWord = addr ^ 32'h5A5A0000;
    endcase
  endfunction

  always_comb begin
    imemReady = imemReq && memOn && (waitCnt >= memLat - 1);
    imemData  = imemReady ? memWord(imemAddr) : 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (rst || !imemReq || imemReady) waitCnt <= 0;
    else                              waitCnt <= waitCnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
    memOn = 1'b1; memLat = 1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
    memOn = 1'b1; memLat = 1;
    tick(); tick();
    $display("reset: req=%0b valid=%0b inst=%h err=%0b", imemReq, validOut, instOut, fetchErr);
    vecCount++; if (imemReq !== 1'b0) begin errCount++; $display("FAIL reset_req: got %0b want 0", imemReq); end
    vecCount++; if (validOut !== 1'b0) begin errCount++; $display("FAIL reset_valid: got %0b want 0", validOut); end
    vecCount++; if (instOut !== 32'h0) begin errCount++; $display("FAIL reset_inst: got %h want 0", instOut); end
    vecCount++; if (pcOut !== 32'h0) begin errCount++; $display("FAIL reset_pc: got %h want 0", pcOut); end
    vecCount++; if (fetchErr !== 1'b0) begin errCount++; $display("FAIL reset_err: got %0b want 0", fetchErr); end
    vecCount++; if (fetchCount !== 32'h0 || stallCount !== 32'h0) begin
      errCount++; $display("FAIL reset_perf: got %h/%h want 0/0", fetchCount, stallCount); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] expWords [3];
    expWords[0] = 32'h20080001; expWords[1] = 32'h20090002; expWords[2] = 32'h01095020;
    doReset();
    vecCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      errCount++; $display("FAIL zw_first_req: got req=%0b addr=%h want 1/0", imemReq, imemAddr); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      $display("zero-wait: addr=%h pcOut=%h inst=%h valid=%0b", imemAddr, pcOut, instOut, validOut);
      vecCount++; if (pcOut !== 32'(4 * k) || instOut !== expWords[k-1] || validOut !== 1'b1) begin
        errCount++; $display("FAIL zw_out%0d: got pc=%h inst=%h v=%0b want pc=%h inst=%h v=1",
                             k, pcOut, instOut, validOut, 32'(4 * k), expWords[k-1]); end
      vecCount++; if (imemAddr !== 32'(4 * k)) begin
        errCount++; $display("FAIL zw_addr%0d: got %h want %h", k, imemAddr, 32'(4 * k)); end
    end
`ifdef IF_PERF_COUNTERS_EN
    vecCount++; if (fetchCount !== 32'd3) begin errCount++; $display("FAIL zw_fetchcount: got %0d want 3", fetchCount); end
`else
    vecCount++; if (fetchCount !== 32'd0) begin errCount++; $display("FAIL zw_fetchcount: got %0d want 0", fetchCount); end
`endif
  endtask

  task automatic test_latency();
    doReset();
    memLat = 3;
    for (int k = 1; k <= 2; k++) begin
      tick();
      $display("latency: cyc=%0d addr=%h valid=%0b inst=%h", k, imemAddr, validOut, instOut);
      vecCount++; if (imemAddr !== 32'h0 || imemReq !== 1'b1) begin
        errCount++; $display("FAIL lat_addr%0d: got req=%0b addr=%h want 1/0", k, imemReq, imemAddr); end
      vecCount++; if (validOut !== 1'b0 || instOut !== 32'h0) begin
        errCount++; $display("FAIL lat_bubble%0d: got v=%0b inst=%h want 0/0", k, validOut, instOut); end
    end
    tick();
    $display("latency: cyc=3 pcOut=%h inst=%h valid=%0b", pcOut, instOut, validOut);
    vecCount++; if (validOut !== 1'b1 || pcOut !== 32'h4 || instOut !== 32'h20080001) begin
      errCount++; $display("FAIL lat_out: got v=%0b pc=%h inst=%h want 1/4/20080001", validOut, pcOut, instOut); end
  endtask

  task automatic test_stall();
    doReset();
    tick();
    stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      $display("stall: cyc=%0d req=%0b pcOut=%h inst=%h valid=%0b", k, imemReq, pcOut, instOut, validOut);
      vecCount++; if (pcOut !== 32'h4 || instOut !== 32'h20080001 || validOut !== 1'b1) begin
        errCount++; $display("FAIL stall_frozen%0d: got pc=%h inst=%h v=%0b want 4/20080001/1", k, pcOut, instOut, validOut); end
      vecCount++; if (imemReq !== 1'b0) begin errCount++; $display("FAIL stall_req%0d: got %0b want 0", k, imemReq); end
    end
    stall = 1'b0;
    tick();
    $display("stall release: pcOut=%h inst=%h addr=%h", pcOut, instOut, imemAddr);
    vecCount++; if (pcOut !== 32'h8 || instOut !== 32'h20090002 || validOut !== 1'b1) begin
      errCount++; $display("FAIL stall_release: got pc=%h inst=%h v=%0b want 8/20090002/1", pcOut, instOut, validOut); end
    vecCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h8) begin
      errCount++; $display("FAIL stall_nextreq: got req=%0b addr=%h want 1/8", imemReq, imemAddr); end
`ifdef IF_PERF_COUNTERS_EN
    vecCount++; if (stallCount !== 32'd3 || fetchCount !== 32'd2) begin
      errCount++; $display("FAIL stall_perf: got %0d/%0d want 3/2", stallCount, fetchCount); end
`endif
  endtask

  task automatic test_redirect_wait();
    doReset();
    tick(); tick();
    memLat = 3;
    redirect = 1'b1; redirectPc = 32'h100;
    tick();
    redirect = 1'b0;
    $display("redirect: drop addr=%h valid=%0b", imemAddr, validOut);
    vecCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h8 || validOut !== 1'b0) begin
      errCount++; $display("FAIL redir_keep1: got req=%0b addr=%h v=%0b want 1/8/0", imemReq, imemAddr, validOut); end
    tick();
    vecCount++; if (imemAddr !== 32'h8 || validOut !== 1'b0) begin
      errCount++; $display("FAIL redir_keep2: got addr=%h v=%0b want 8/0", imemAddr, validOut); end
    tick();
    $display("redirect: new addr=%h valid=%0b inst=%h", imemAddr, validOut, instOut);
    vecCount++; if (imemAddr !== 32'h100 || validOut !== 1'b0 || instOut !== 32'h0) begin
      errCount++; $display("FAIL redir_target: got addr=%h v=%0b inst=%h want 100/0/0", imemAddr, validOut, instOut); end
    memLat = 1;
    tick();
    vecCount++; if (validOut !== 1'b1 || pcOut !== 32'h104 || instOut !== 32'h5A5A0100) begin
      errCount++; $display("FAIL redir_out: got v=%0b pc=%h inst=%h want 1/104/5a5a0100", validOut, pcOut, instOut); end
  endtask

  task automatic test_timeout();
    doReset();
    memOn = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    vecCount++; if (fetchErr !== 1'b0 || imemReq !== 1'b1) begin
      errCount++; $display("FAIL wd_early: got err=%0b req=%0b want 0/1", fetchErr, imemReq); end
    tick();
    $display("watchdog: err=%0b req=%0b valid=%0b", fetchErr, imemReq, validOut);
    vecCount++; if (fetchErr !== 1'b1 || imemReq !== 1'b0 || validOut !== 1'b0) begin
      errCount++; $display("FAIL wd_fire: got err=%0b req=%0b v=%0b want 1/0/0", fetchErr, imemReq, validOut); end
    rst = 1'b1;
    tick();
    rst = 1'b0; memOn = 1'b1;
    #1;
    vecCount++; if (fetchErr !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      errCount++; $display("FAIL wd_recover: got err=%0b req=%0b addr=%h want 0/1/0", fetchErr, imemReq, imemAddr); end
  endtask

  task automatic test_redirect_stall();
    doReset();
    redirect = 1'b1; stall = 1'b1; redirectPc = 32'h103;
    tick();
    redirect = 1'b0; stall = 1'b0;
    $display("redirect+stall: addr=%h valid=%0b stallCount=%0d", imemAddr, validOut, stallCount);
    vecCount++; if (imemAddr !== 32'h100 || imemReq !== 1'b1 || validOut !== 1'b0) begin
      errCount++; $display("FAIL rs_target: got addr=%h req=%0b v=%0b want 100/1/0", imemAddr, imemReq, validOut); end
`ifdef IF_PERF_COUNTERS_EN
    vecCount++; if (stallCount !== 32'd1) begin errCount++; $display("FAIL rs_stallcount: got %0d want 1", stallCount); end
`else
    vecCount++; if (stallCount !== 32'd0) begin errCount++; $display("FAIL rs_stallcount: got %0d want 0", stallCount); end
`endif
    tick();
    vecCount++; if (validOut !== 1'b1 || pcOut !== 32'h104) begin
      errCount++; $display("FAIL rs_out: got v=%0b pc=%h want 1/104", validOut, pcOut); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_wait();
    test_timeout();
    test_redirect_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage of the mips32 pipeline. It owns the program counter, issues word requests to instruction memory over a req/ready handshake, and presents registered {PC+4, instruction, valid} to the IF/ID pipeline register. It honours stall from the hazard unit and redirect from branch/jump resolution, discards stale in-flight responses, and flags a hung memory with a watchdog.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset; low 2 bits must be 0.
TIMEOUT_CYCLES, 16, number of consecutive unanswered request cycles before fetchErr is set; 0 disables the watchdog.

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
stall  input  1  hazard unit: hold outputs, do not advance PC
redirect  input  1  taken branch/jump this cycle
redirectPc  input  32  redirect target
imemReq  output  1  fetch request
imemAddr  output  32  fetch word address, stable while imemReq is high and imemReady is low
imemReady  input  1  response valid this cycle; may be high in the same cycle as the request
imemData  input  32  instruction word, valid when imemReady is high
pcOut  output  32  PC+4 of instOut (to IF/ID pcIn)
instOut  output  32  fetched instruction (to IF/ID instIn); 0 (nop) when not valid
validOut  output  1  instOut/pcOut carry a real instruction
fetchErr  output  1  sticky watchdog error
fetchCount  output  32  perf counter (see Optional Feature)
stallCount  output  32  perf counter (see Optional Feature)

Behaviour:
- Interface as decided: one clock, clk; reset rst, synchronous and active-high.
- Reset (rst high at posedge): pc<=RESET_PC, state<=FETCH, pcOut/instOut/validOut/fetchErr<=0, watchdog and perf counters<=0. imemReq is 0 while rst is high. rst mid-request abandons the request; a late imemReady is ignored.
- Priority per cycle: rst > redirect > stall > normal fetch.
- redirectPc[1:0] is forced to 0. pc+4 wraps modulo 2^32.
- imemReq = 1 in FETCH and DROP; imemAddr = reqPc register.
- FETCH, imemReady=1:
  - redirect: drop data; pc<=redirectPc; output bubble (validOut 0, instOut 0); stay in FETCH.
  - stall: latch imemData into holdBuf; outputs unchanged; go to HOLD.
  - otherwise: instOut<=imemData, pcOut<=reqPc+4, validOut<=1, pc<=reqPc+4; issue the next request the following cycle.
- FETCH, imemReady=0:
  - redirect: pendPc<=redirectPc; go to DROP.
  - stall: outputs held.
  - otherwise: bubble.
- DROP: keep the old request until imemReady, then discard the data; pc<=pendPc; go to FETCH. A further redirect in DROP overwrites pendPc. Outputs are bubbles unless stall is high (held).
- HOLD: imemReq=0, outputs held.
  - stall falls: present holdBuf (validOut 1, pcOut=reqPc+4); pc+=4; go to FETCH.
  - redirect: discard holdBuf; pc<=redirectPc; bubble; go to FETCH.
- Latency with zero-wait memory: request in cycle N, outputs valid after the posedge ending cycle N. Throughput is 1 instruction per cycle.
- Watchdog: counts cycles with imemReq=1 and imemReady=0, and clears on imemReady. When the count reaches TIMEOUT_CYCLES: go to ERR, fetchErr<=1, imemReq=0, validOut<=0, instOut<=0. ERR is left only by rst.

Optional Feature:
IF_PERF_COUNTERS_EN
- Defined: fetchCount increments on every cycle validOut is loaded with 1. stallCount increments on every cycle stall=1 and state is not ERR. Both wrap at 2^32 and clear on rst.
- Undefined: counters are not built; fetchCount and stallCount are tied to 0.

Test Plan:
- Reset, RESET_PC=0, zero-wait memory holding mem[0..2]=0x20080001,0x20090002,0x01095020 -> imemAddr 0,4,8 on consecutive cycles; pcOut 4,8,12 with matching instOut and validOut=1 from the first cycle after the first request.
- Memory with 3-cycle latency -> imemAddr held at 0 for 3 cycles; validOut=0 with instOut=0 for 2 cycles, then one valid output (pcOut=4).
- stall=1 in the cycle imemReady arrives for addr 4, held 3 cycles -> outputs frozen at the addr-0 instruction, imemReq=0; on release, next output is pcOut=8 with the buffered word, then a request to 8.
- redirect=1 with redirectPc=0x100 during a wait on addr 8 -> request to 8 kept until ready, its data never appears on validOut; next imemAddr=0x100.
- TIMEOUT_CYCLES=8, imemReady held 0 -> fetchErr=1 after 8 waiting cycles, imemReq=0; rst for 1 cycle -> fetchErr=0 and a request to RESET_PC.
- redirect=1 and stall=1 in the same cycle with redirectPc=0x103 -> stall ignored, next imemAddr=0x100. With IF_PERF_COUNTERS_EN defined, stallCount increments by 1.
